change_dispenser: RTL

Refund and change dispenser for the candy-vending datapath. It takes a refund amount from the vending controller and emits it to the coin-output mechanism one coin at a time, largest denomination first. Coins use the same 2-bit coin code as the vending controller's coin input. It sits between the vending FSM (cancel, and candy-plus-change outcomes) and the physical coin ejector.

---
 rtl/change_pkg.sv | 31 +++
 rtl/change_dispenser_coin_select.sv | 47 ++++
 rtl/change_dispenser.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/change_pkg.sv
// Shared definitions for the change dispenser: coin codes, coin values,
// controller state encoding and a coin-code-to-value helper.
package change_pkg;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_5    = 2'b01;
    localparam logic [1:0] COIN_10   = 2'b10;
    localparam logic [1:0] COIN_25   = 2'b11;

    localparam int unsigned VAL_5  = 5;
    localparam int unsigned VAL_10 = 10;
    localparam int unsigned VAL_25 = 25;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_ISSUE,
        ST_DONE,
        ST_ERR
    } state_t;

    function automatic logic [7:0] coin_value(input logic [1:0] code);
        case (code)
            COIN_5:  coin_value = 8'(VAL_5);
            COIN_10: coin_value = 8'(VAL_10);
            COIN_25: coin_value = 8'(VAL_25);
            default: coin_value = 8'd0;
        endcase
    endfunction

endpackage

// File: rtl/change_dispenser_coin_select.sv
// Combinational greedy coin picker: largest coin that fits the remaining
// amount. With CHANGE_DISPENSER_INV_EN the coin must also be in stock, and
// none_fit flags that nothing qualifies; otherwise stock is unlimited.
module coin_select
    import change_pkg::*;
#(
    parameter int AMT_W = 7
)
(
    input  logic [AMT_W-1:0] remaining,
`ifdef CHANGE_DISPENSER_INV_EN
    input  logic [2:0]       stock_ok,   // {25, 10, 5} stock nonzero
`endif
    output logic [1:0]       code,
    output logic             none_fit
);

    localparam logic [AMT_W-1:0] V5  = AMT_W'(VAL_5);
    localparam logic [AMT_W-1:0] V10 = AMT_W'(VAL_10);
    localparam logic [AMT_W-1:0] V25 = AMT_W'(VAL_25);

    // Pick the largest qualifying denomination.
    always_comb begin
        code     = COIN_NONE;
        none_fit = 1'b0;
`ifdef CHANGE_DISPENSER_INV_EN
        if (remaining >= V25 && stock_ok[2]) begin
            code = COIN_25;
        end else if (remaining >= V10 && stock_ok[1]) begin
            code = COIN_10;
        end else if (remaining >= V5 && stock_ok[0]) begin
            code = COIN_5;
        end else begin
            none_fit = 1'b1;
        end
`else
        if (remaining >= V25) begin
            code = COIN_25;
        end else if (remaining >= V10) begin
            code = COIN_10;
        end else begin
            code = COIN_5;
        end
`endif
    end

endmodule

// File: rtl/change_dispenser.sv
// Refund/change dispenser: accepts a refund amount and hands it to the coin
// ejector one coin at a time, largest denomination first, with a
// valid/ack handshake per coin. Optional feature macro
// CHANGE_DISPENSER_INV_EN adds per-denomination stock counters and a
// refill input.
module change_dispenser
    import change_pkg::*;
#(
    parameter int AMT_W    = 7,
    parameter int MAX_AMT  = 100,
    parameter int INV_INIT = 8
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic [AMT_W-1:0] amount,
    output logic [1:0]       coin,
    output logic             coin_valid,
    input  logic             coin_ack,
`ifdef CHANGE_DISPENSER_INV_EN
    input  logic             refill,
`endif
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam logic [AMT_W-1:0] MAX_V = AMT_W'(MAX_AMT);
    localparam logic [AMT_W-1:0] FIVE  = AMT_W'(VAL_5);

    state_t           state_q, state_d;
    logic [AMT_W-1:0] remaining_q;
    logic [AMT_W-1:0] rem_next;
    logic [1:0]       coin_q;
    logic [1:0]       sel_code;
    logic             sel_none;
    logic             req_bad;

    // Out of range or not a whole number of nickels.
    assign req_bad  = (amount > MAX_V) || ((amount % FIVE) != '0);
    assign rem_next = remaining_q - AMT_W'(coin_value(coin_q));

`ifdef CHANGE_DISPENSER_INV_EN
    localparam int INV_W = (INV_INIT < 1) ? 1 : $clog2(INV_INIT + 1);

    logic [INV_W-1:0] s5_q, s10_q, s25_q;
    logic [2:0]       stock_ok;

    assign stock_ok = {s25_q != '0, s10_q != '0, s5_q != '0};

    // Stock counters: refilled from IDLE, decremented on each accepted coin.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s5_q  <= INV_W'(INV_INIT);
            s10_q <= INV_W'(INV_INIT);
            s25_q <= INV_W'(INV_INIT);
        end else if (state_q == ST_IDLE && refill) begin
            s5_q  <= INV_W'(INV_INIT);
            s10_q <= INV_W'(INV_INIT);
            s25_q <= INV_W'(INV_INIT);
        end else if (state_q == ST_ISSUE && coin_ack) begin
            case (coin_q)
                COIN_5:  s5_q  <= s5_q  - INV_W'(1);
                COIN_10: s10_q <= s10_q - INV_W'(1);
                COIN_25: s25_q <= s25_q - INV_W'(1);
                default: ;
            endcase
        end
    end

    coin_select #(.AMT_W(AMT_W)) u_coin_select (
        .remaining (remaining_q),
        .stock_ok  (stock_ok),
        .code      (sel_code),
        .none_fit  (sel_none)
    );
`else
    coin_select #(.AMT_W(AMT_W)) u_coin_select (
        .remaining (remaining_q),
        .code      (sel_code),
        .none_fit  (sel_none)
    );
`endif

    // Controller state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake/status outputs.
    always_comb begin
        state_d    = state_q;
        coin_valid = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        err        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (req) begin
                    if (req_bad) begin
                        state_d = ST_ERR;
                    end else if (amount == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SELECT;
                    end
                end
            end
            ST_SELECT: begin
                state_d = sel_none ? ST_ERR : ST_ISSUE;
            end
            ST_ISSUE: begin
                coin_valid = 1'b1;
                if (coin_ack) begin
                    state_d = (rem_next == '0) ? ST_DONE : ST_SELECT;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            ST_ERR: begin
                err     = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Coin code is only driven while presented to the ejector.
    assign coin = coin_valid ? coin_q : COIN_NONE;

    // Remaining amount and selected coin registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            remaining_q <= '0;
            coin_q      <= COIN_NONE;
        end else begin
            case (state_q)
                ST_IDLE:   if (req) remaining_q <= amount;
                ST_SELECT: coin_q <= sel_code;
                ST_ISSUE:  if (coin_ack) remaining_q <= rem_next;
                ST_ERR:    remaining_q <= '0;
                default:   ;
            endcase
        end
    end

endmodule
